aes_multiblock_fsm: RTL and testbench

- Parametrised control FSM for the AES HWPE engine. It sequences encryption of N consecutive 128-bit blocks per job.
- Supports ECB and CBC chaining modes, waits for key expansion, and counts completed blocks.
- Includes a per-block watchdog and reports done/error to the slave control unit.
- Sits between the HWPE slave/regfile, the source/sink streamers and the AES datapath engine.

---
 rtl/aes_multiblock_fsm_pkg.sv | 21 ++
 rtl/aes_multiblock_fsm_watchdog.sv | 38 +++
 rtl/aes_multiblock_fsm.sv | 145 ++++++++++++++
 tb/tb_aes_multiblock_fsm.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_multiblock_fsm_pkg.sv
// Shared types and constants for the AES multi-block job sequencer.
package aes_multiblock_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    STARTING,
    WORKING,
    DRAIN,
    FINISHED,
    ERROR
  } aes_mb_state_t;

  typedef enum logic {
    AES_MODE_ECB = 1'b0,
    AES_MODE_CBC = 1'b1
  } aes_mode_e;

  localparam int AES_BLOCK_BYTES = 16;

endpackage

// File: rtl/aes_multiblock_fsm_watchdog.sv
// Saturating inactivity counter: flags expiry on the cycle the count reaches TIMEOUT_CYC.
module aes_fsm_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en_i,
  input  logic restart_i,
  output logic expired_o
);

  if (TIMEOUT_CYC > 0) begin : g_wd
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = (cnt_q == LIMIT) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else if (clear || !en_i || restart_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_inc;
      end
    end

    // A restart in the same cycle always beats expiry.
    assign expired_o = en_i & ~restart_i & (cnt_inc == LIMIT);
  end else begin : g_off
    assign expired_o = 1'b0;
  end

endmodule

// File: rtl/aes_multiblock_fsm.sv
// Job sequencer for the AES HWPE: key expansion, streamer start, block counting, drain and watchdog.
module aes_multiblock_fsm
  import aes_multiblock_fsm_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int NBLK_W      = 16,
  parameter int BLOCK_BYTES = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              start_i,
  input  logic [NBLK_W-1:0] nblocks_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  output logic              src_req_start_o,
  input  logic              src_ready_start_i,
  output logic              sink_req_start_o,
  input  logic              sink_ready_start_i,
  input  logic              sink_done_i,
  output logic [ADDR_W-1:0] stream_base_src_o,
  output logic [ADDR_W-1:0] stream_base_dst_o,
  output logic [NBLK_W-1:0] stream_len_o,
  output logic              eng_clear_o,
  output logic              eng_start_o,
  output logic              eng_enable_o,
  output logic              eng_iv_load_o,
  input  logic              eng_key_ready_i,
  input  logic              eng_block_done_i,
  output logic [NBLK_W-1:0] blocks_done_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  // The streamers walk addresses in whole AES blocks; any other stride is a wiring mistake.
  if (BLOCK_BYTES != AES_BLOCK_BYTES) begin : g_bad_stride
    $error("aes_multiblock_fsm: BLOCK_BYTES must equal AES_BLOCK_BYTES");
  end

  aes_mb_state_t     state_q, state_d;
  aes_mode_e         mode_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [NBLK_W-1:0] len_q, blocks_done_q;
  logic              err_q, kfirst_q, eng_clear_q;
  logic              wd_expired;
  logic              last_block;

  assign last_block = eng_block_done_i && ((blocks_done_q + NBLK_W'(1)) == len_q);

  aes_fsm_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .en_i     ((state_q == WORKING) || (state_q == DRAIN)),
    .restart_i(eng_block_done_i),
    .expired_o(wd_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start_i) state_d = (nblocks_i == '0) ? FINISHED : KEYEXP;
      KEYEXP:   if (eng_key_ready_i) state_d = STARTING;
      STARTING: if (src_ready_start_i && sink_ready_start_i) state_d = WORKING;
      WORKING: begin
        if (last_block)      state_d = DRAIN;
        else if (wd_expired) state_d = ERROR;
      end
      DRAIN: begin
        if (sink_done_i || sink_ready_start_i) state_d = FINISHED;
        else if (wd_expired)                   state_d = ERROR;
      end
      FINISHED: state_d = IDLE;
      ERROR:    state_d = ERROR;
      default:  state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_comb begin
    src_req_start_o  = (state_q == STARTING);
    sink_req_start_o = (state_q == STARTING);
    eng_enable_o     = (state_q == KEYEXP) || (state_q == STARTING) ||
                       (state_q == WORKING) || (state_q == DRAIN);
    eng_start_o      = (state_q == KEYEXP) && kfirst_q;
    eng_iv_load_o    = (state_q == KEYEXP) && kfirst_q && (mode_q == AES_MODE_CBC);
    busy_o           = (state_q != IDLE);
    done_o           = (state_q == FINISHED);
  end

  // Job context, counters and the registered engine-clear level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q        <= AES_MODE_ECB;
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      blocks_done_q <= '0;
      err_q         <= 1'b0;
      kfirst_q      <= 1'b0;
      eng_clear_q   <= 1'b0;
    end else if (clear) begin
      mode_q        <= AES_MODE_ECB;
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      blocks_done_q <= '0;
      err_q         <= 1'b0;
      kfirst_q      <= 1'b0;
      eng_clear_q   <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start_i) begin
        mode_q        <= aes_mode_e'(mode_i);
        src_q         <= src_base_i;
        dst_q         <= dst_base_i;
        len_q         <= nblocks_i;
        blocks_done_q <= '0;
        err_q         <= 1'b0;
      end
      if ((state_q == WORKING) && eng_block_done_i) blocks_done_q <= blocks_done_q + NBLK_W'(1);
      if (state_d == ERROR) err_q <= 1'b1;
      // KEYEXP is only ever entered from IDLE, so this marks its first cycle.
      kfirst_q    <= (state_q == IDLE);
      eng_clear_q <= (state_d == IDLE) || (state_d == ERROR);
    end
  end

  assign stream_base_src_o = src_q;
  assign stream_base_dst_o = dst_q;
  assign stream_len_o      = len_q;
  assign blocks_done_o     = blocks_done_q;
  assign err_o             = err_q;
  assign eng_clear_o       = eng_clear_q;

endmodule

// File: tb/tb_aes_multiblock_fsm.sv
// Randomized and directed bench for aes_multiblock_fsm against a cycle-level job model.
module tb_aes_multiblock_fsm;
  localparam int ADDR_W = 32;
  localparam int NBLK_W = 16;
  localparam int TO     = 64;

  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, start_i = 1'b0, mode_i = 1'b0;
  logic src_ready = 1'b0, sink_ready = 1'b0, sink_done = 1'b0, key_ready = 1'b0, blk_done = 1'b0;
  logic [NBLK_W-1:0] nblocks_i = '0;
  logic [ADDR_W-1:0] src_base_i = '0, dst_base_i = '0;

  logic src_req_start_o, sink_req_start_o, eng_clear_o, eng_start_o, eng_enable_o, eng_iv_load_o;
  logic busy_o, done_o, err_o;
  logic [ADDR_W-1:0] stream_base_src_o, stream_base_dst_o;
  logic [NBLK_W-1:0] stream_len_o, blocks_done_o;

  aes_multiblock_fsm #(.ADDR_W(ADDR_W), .NBLK_W(NBLK_W), .BLOCK_BYTES(16), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start_i(start_i), .nblocks_i(nblocks_i),
    .mode_i(mode_i), .src_base_i(src_base_i), .dst_base_i(dst_base_i),
    .src_req_start_o(src_req_start_o), .src_ready_start_i(src_ready),
    .sink_req_start_o(sink_req_start_o), .sink_ready_start_i(sink_ready), .sink_done_i(sink_done),
    .stream_base_src_o(stream_base_src_o), .stream_base_dst_o(stream_base_dst_o),
    .stream_len_o(stream_len_o), .eng_clear_o(eng_clear_o), .eng_start_o(eng_start_o),
    .eng_enable_o(eng_enable_o), .eng_iv_load_o(eng_iv_load_o), .eng_key_ready_i(key_ready),
    .eng_block_done_i(blk_done), .blocks_done_o(blocks_done_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int n_done = 0, n_sreq = 0, n_kreq = 0, n_estart = 0, n_iv = 0, n_both = 0;

  // Model: job phase 0 idle,1 key expansion,2 starting,3 working,4 drain,5 finished,6 error
  int m_ph, m_idle;
  logic [NBLK_W-1:0] m_len, m_bd;
  logic [ADDR_W-1:0] m_src, m_dst;
  logic m_mode, m_err, m_kf, m_eclr;

  task automatic model_reset();
    m_ph = 0; m_idle = 0; m_len = '0; m_bd = '0; m_src = '0; m_dst = '0;
    m_mode = 1'b0; m_err = 1'b0; m_kf = 1'b0; m_eclr = 1'b0;
  endtask

  task automatic model_step();
    int prev;
    if (clear) begin
      model_reset();
      return;
    end
    prev = m_ph;
    case (m_ph)
      0: if (start_i) begin
        m_len = nblocks_i; m_mode = mode_i; m_src = src_base_i; m_dst = dst_base_i;
        m_bd = '0; m_err = 1'b0;
        m_ph = (nblocks_i == 0) ? 5 : 1;
      end
      1: if (key_ready) m_ph = 2;
      2: if (src_ready && sink_ready) begin m_ph = 3; m_idle = 0; end
      3: if (blk_done) begin
        m_bd = m_bd + 1'b1; m_idle = 0;
        if (m_bd == m_len) m_ph = 4;
      end else begin
        m_idle++;
        if (TO > 0 && m_idle >= TO) begin m_ph = 6; m_err = 1'b1; end
      end
      4: begin
        if (blk_done) m_idle = 0; else m_idle++;
        if (sink_done || sink_ready) m_ph = 5;
        else if (TO > 0 && m_idle >= TO) begin m_ph = 6; m_err = 1'b1; end
      end
      5: m_ph = 0;
      default: ;
    endcase
    m_kf   = (m_ph == 1) && (prev != 1);
    m_eclr = (m_ph == 0) || (m_ph == 6);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  function automatic logic [104:0] act_vec();
    return {src_req_start_o, sink_req_start_o, stream_base_src_o, stream_base_dst_o, stream_len_o,
            eng_clear_o, eng_start_o, eng_enable_o, eng_iv_load_o, blocks_done_o, busy_o, done_o, err_o};
  endfunction

  initial begin
    logic [104:0] a, e;
    forever begin
      @(negedge clk);
      a = act_vec();
      e = {m_ph == 2, m_ph == 2, m_src, m_dst, m_len, m_eclr, (m_ph == 1) && m_kf,
           (m_ph >= 1) && (m_ph <= 4), (m_ph == 1) && m_kf && m_mode, m_bd, m_ph != 0, m_ph == 5, m_err};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, a, e);
      end
      n_done   += int'(done_o);
      n_sreq   += int'(src_req_start_o);
      n_kreq   += int'(sink_req_start_o);
      n_estart += int'(eng_start_o);
      n_iv     += int'(eng_iv_load_o);
      n_both   += int'(eng_start_o && eng_iv_load_o);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_mon();
    n_done = 0; n_sreq = 0; n_kreq = 0; n_estart = 0; n_iv = 0; n_both = 0;
  endtask

  task automatic job(input int n, input logic m);
    nblocks_i = NBLK_W'(n); mode_i = m; src_base_i = $urandom; dst_base_i = $urandom;
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic pulse_blk();
    blk_done = 1'b1; tick(); blk_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) tick();
    check("reset_busy", busy_o, 0);
    check("reset_eng_clear", eng_clear_o, 0);
    reset_n = 1'b1;
    repeat (2) tick();
    check("idle_eng_clear", eng_clear_o, 1);

    // ECB, four blocks spaced 12 cycles, sink_done closes the drain
    clr_mon(); src_ready = 1'b1; sink_ready = 1'b1;
    job(4, 1'b0);
    repeat (3) tick(); key_ready = 1'b1;
    repeat (4) tick(); sink_ready = 1'b0; key_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin repeat (11) tick(); pulse_blk(); end
    repeat (3) tick();
    check("drain_wait_busy", busy_o, 1);
    sink_done = 1'b1; tick(); sink_done = 1'b0; repeat (3) tick();
    check("ecb_done_pulses", n_done, 1);
    check("ecb_blocks_done", blocks_done_o, 4);
    check("ecb_err", err_o, 0);
    check("ecb_src_req_cycles", n_sreq, 1);
    check("ecb_sink_req_cycles", n_kreq, 1);
    check("ecb_iv_load", n_iv, 0);
    check("ecb_eng_start", n_estart, 1);

    // Zero-length job
    clr_mon(); sink_ready = 1'b1;
    job(0, 1'b0);
    check("zero_done_now", done_o, 1);
    tick();
    check("zero_done_pulses", n_done, 1);
    check("zero_req", n_sreq, 0);
    check("zero_eng_start", n_estart, 0);

    // CBC, two blocks
    clr_mon();
    job(2, 1'b1);
    repeat (2) tick(); key_ready = 1'b1;
    repeat (3) tick();
    pulse_blk(); repeat (4) tick(); pulse_blk(); repeat (3) tick();
    key_ready = 1'b0;
    check("cbc_eng_start", n_estart, 1);
    check("cbc_iv_load", n_iv, 1);
    check("cbc_coincide", n_both, 1);
    check("cbc_done", n_done, 1);
    check("cbc_blocks_done", blocks_done_o, 2);

    // Watchdog expiry 64 cycles after the only block
    clr_mon(); key_ready = 1'b1;
    job(3, 1'b0);
    repeat (4) tick(); sink_ready = 1'b0;
    pulse_blk();
    repeat (63) tick();
    check("wd_not_yet", err_o, 0);
    tick();
    check("wd_expired", err_o, 1);
    repeat (20) tick();
    check("wd_sticky", err_o, 1);
    check("wd_no_done", n_done, 0);
    check("err_eng_clear", eng_clear_o, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_err", err_o, 0);
    check("clear_busy", busy_o, 0);

    // Stalled source streamer, ignored restart, final block racing expiry
    clr_mon(); src_ready = 1'b0; sink_ready = 1'b1;
    job(2, 1'b0);
    k = 0;
    while (!src_req_start_o && k < 50) begin tick(); k++; end
    check("stall_req_seen", src_req_start_o, 1);
    repeat (10) tick();
    check("stall_req_held", src_req_start_o, 1);
    src_ready = 1'b1; tick(); tick();
    check("stall_req_dropped", src_req_start_o, 0);
    check("stall_req_long", n_sreq >= 11, 1);
    sink_ready = 1'b0;
    nblocks_i = 16'd7; start_i = 1'b1; tick(); start_i = 1'b0;
    pulse_blk();
    repeat (63) tick();
    pulse_blk();
    tick();
    check("race_no_err", err_o, 0);
    check("race_drain_busy", busy_o, 1);
    check("race_len_kept", stream_len_o, 2);
    check("race_blocks", blocks_done_o, 2);
    sink_done = 1'b1; tick(); sink_done = 1'b0; tick();
    check("race_done", n_done, 1);

    // Asynchronous reset in the middle of a job
    src_ready = 1'b1; sink_ready = 1'b1;
    job(4, 1'b1);
    repeat (3) tick();
    pulse_blk(); repeat (2) tick(); pulse_blk(); tick();
    check("mid_blocks", blocks_done_o, 2);
    #1 reset_n = 1'b0;
    #1;
    check("reset_all_zero", {41'd0, |act_vec()}, 0);
    repeat (2) tick();
    reset_n = 1'b1; tick(); clr_mon();
    job(1, 1'b0);
    repeat (4) tick(); pulse_blk(); repeat (3) tick();
    check("post_reset_done", n_done, 1);
    check("post_reset_blocks", blocks_done_o, 1);
    check("post_reset_err", err_o, 0);

    // Random traffic; the cycle compare carries the checking
    for (int seg = 0; seg < 6; seg++) begin
      int p_blk;
      p_blk = (seg % 2 == 0) ? 8 : 90;
      for (int c = 0; c < 500; c++) begin
        start_i    = ($urandom_range(0, 19) == 0);
        nblocks_i  = NBLK_W'($urandom_range(0, 5));
        mode_i     = $urandom_range(0, 1) == 1;
        src_base_i = $urandom;
        dst_base_i = $urandom;
        if ($urandom_range(0, 5) == 0) key_ready = ~key_ready;
        src_ready  = ($urandom_range(0, 3) != 0);
        sink_ready = ($urandom_range(0, 2) == 0);
        blk_done   = ($urandom_range(0, p_blk - 1) == 0);
        sink_done  = ($urandom_range(0, 9) == 0);
        clear      = ($urandom_range(0, 249) == 0);
        tick();
      end
    end
    start_i = 1'b0; blk_done = 1'b0; sink_done = 1'b0; clear = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
